// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the Fetch stage: a direct-mapped BTB with
// per-entry saturating direction counters and optional gshare indexing.
// Decode resolves branches and feeds them back for verification and training.
//
// state | meaning
// INIT  | sweeping the table: one entry per cycle invalidated, ctr set weak not-taken
// RUN   | table usable; lookups predict, resolved branches train the table
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int GHR_WIDTH  = 0,
  localparam int IDXW      = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PCF,
  output logic                  PredTakenF,
  output logic [ADDR_WIDTH-1:0] PredTargetF,
  output logic [IDXW-1:0]       PredIdxF,
  input  logic                  UpdateValidD,
  input  logic [ADDR_WIDTH-1:0] UpdatePCD,
  input  logic [IDXW-1:0]       UpdateIdxD,
  input  logic                  UpdateTakenD,
  input  logic [ADDR_WIDTH-1:0] UpdateTargetD,
  input  logic                  UpdatePredTakenD,
  input  logic [ADDR_WIDTH-1:0] UpdatePredTargetD,
  output logic                  MispredictD,
  output logic [ADDR_WIDTH-1:0] CorrectPCD,
  output logic                  Ready,
  output logic [31:0]           BranchCount,
  output logic [31:0]           MispredCount
);

  localparam int TAGW = ADDR_WIDTH - IDXW - 2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(ENTRIES - 1);
  // Weak not-taken: msb clear, lower bits set. Weak taken: msb set, rest clear.
  localparam logic [CTR_WIDTH-1:0]  CTR_WNT  = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0]  CTR_WT   = CTR_WIDTH'(1 << (CTR_WIDTH - 1));

  typedef enum logic {INIT, RUN} state_t;

  state_t state, nextState;
  logic [IDXW-1:0] sweepPtr;

  logic                  validTab  [ENTRIES];
  logic [TAGW-1:0]       tagTab    [ENTRIES];
  logic [ADDR_WIDTH-1:0] targetTab [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctrTab    [ENTRIES];

  logic [IDXW-1:0]      ghrIdx;
  logic [IDXW-1:0]      lookupIdx;
  logic                 lookupHit;
  logic                 doUpdate;
  logic                 updHit;
  logic [CTR_WIDTH-1:0] ctrCur;
  logic [CTR_WIDTH-1:0] ctrNext;
  logic [31:0]          branchCnt;
  logic [31:0]          mispredCnt;

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= nextState;
  end

  // Leave INIT once the last entry has been swept.
  always_comb begin
    nextState = state;
    if (state == INIT && sweepPtr == LAST_IDX) nextState = RUN;
  end

  assign Ready    = (state == RUN);
  assign doUpdate = UpdateValidD && Ready;

  // Sweep pointer walks the table once per INIT pass.
  always_ff @(posedge clk) begin
    if (!reset)              sweepPtr <= '0;
    else if (state == INIT)  sweepPtr <= sweepPtr + IDXW'(1);
  end

  // Global history is only built in gshare mode; bimodal indexes by PC alone.
  generate
    if (GHR_WIDTH > 0) begin : genGshare
      logic [GHR_WIDTH-1:0] ghr;
      // Non-speculative history: shifted only by resolved branches.
      always_ff @(posedge clk) begin
        if (!reset)        ghr <= '0;
        else if (doUpdate) ghr <= GHR_WIDTH'({ghr, UpdateTakenD});
      end
      assign ghrIdx = IDXW'(ghr);
    end else begin : genBimodal
      assign ghrIdx = '0;
    end
  endgenerate

  // Same-cycle lookup against the current table contents.
  always_comb begin
    lookupIdx   = PCF[IDXW+1:2] ^ ghrIdx;
    lookupHit   = validTab[lookupIdx] && (tagTab[lookupIdx] == PCF[ADDR_WIDTH-1:IDXW+2]);
    PredTakenF  = Ready && lookupHit && ctrTab[lookupIdx][CTR_WIDTH-1];
    PredTargetF = PredTakenF ? targetTab[lookupIdx] : PCF + PC_STEP;
    PredIdxF    = lookupIdx;
  end

  // Verify the carried prediction against the resolved outcome.
  always_comb begin
    MispredictD = UpdateValidD &&
                  ((UpdatePredTakenD != UpdateTakenD) ||
                   (UpdateTakenD && (UpdatePredTargetD != UpdateTargetD)));
    CorrectPCD  = UpdateTakenD ? UpdateTargetD : UpdatePCD + PC_STEP;
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    updHit  = validTab[UpdateIdxD] && (tagTab[UpdateIdxD] == UpdatePCD[ADDR_WIDTH-1:IDXW+2]);
    ctrCur  = ctrTab[UpdateIdxD];
    ctrNext = ctrCur;
    if (UpdateTakenD) begin
      if (ctrCur != '1) ctrNext = ctrCur + CTR_WIDTH'(1);
    end else begin
      if (ctrCur != '0) ctrNext = ctrCur - CTR_WIDTH'(1);
    end
  end

  // Table writes: sweep during INIT, training/allocation during RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT) begin
        validTab[sweepPtr] <= 1'b0;
        ctrTab[sweepPtr]   <= CTR_WNT;
      end else if (UpdateValidD) begin
        if (updHit) begin
          ctrTab[UpdateIdxD] <= ctrNext;
          if (UpdateTakenD) targetTab[UpdateIdxD] <= UpdateTargetD;
        end else if (UpdateTakenD) begin
          validTab[UpdateIdxD]  <= 1'b1;
          tagTab[UpdateIdxD]    <= UpdatePCD[ADDR_WIDTH-1:IDXW+2];
          targetTab[UpdateIdxD] <= UpdateTargetD;
          ctrTab[UpdateIdxD]    <= CTR_WT;
        end
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else if (doUpdate) begin
      if (branchCnt != '1)                 branchCnt  <= branchCnt + 32'd1;
      if (MispredictD && mispredCnt != '1) mispredCnt <= mispredCnt + 32'd1;
    end
  end

  assign BranchCount  = branchCnt;
  assign MispredCount = mispredCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal instance (dut0) and a gshare instance (dut1)
// share stimulus; dut1 is held in reset until the gshare phase.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [31:0] PCF;
  logic        UpdateValidD, UpdateTakenD, UpdatePredTakenD;
  logic [31:0] UpdatePCD, UpdateTargetD, UpdatePredTargetD;
  logic [3:0]  UpdateIdxD;

  logic        predTaken0, mispred0, ready0;
  logic [31:0] predTarget0, correctPC0, branchCnt0, mispredCnt0;
  logic [3:0]  predIdx0;
  logic        predTaken1, mispred1, ready1;
  logic [31:0] predTarget1, correctPC1, branchCnt1, mispredCnt1;
  logic [3:0]  predIdx1;

  int compared;
  int mismatched;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_WIDTH(32), .ENTRIES(16), .CTR_WIDTH(2), .GHR_WIDTH(0)) dut0 (
    .clk(clk), .reset(rst0), .PCF(PCF),
    .PredTakenF(predTaken0), .PredTargetF(predTarget0), .PredIdxF(predIdx0),
    .UpdateValidD(UpdateValidD), .UpdatePCD(UpdatePCD), .UpdateIdxD(UpdateIdxD),
    .UpdateTakenD(UpdateTakenD), .UpdateTargetD(UpdateTargetD),
    .UpdatePredTakenD(UpdatePredTakenD), .UpdatePredTargetD(UpdatePredTargetD),
    .MispredictD(mispred0), .CorrectPCD(correctPC0), .Ready(ready0),
    .BranchCount(branchCnt0), .MispredCount(mispredCnt0)
  );

  branch_predictor #(.ADDR_WIDTH(32), .ENTRIES(16), .CTR_WIDTH(2), .GHR_WIDTH(4)) dut1 (
    .clk(clk), .reset(rst1), .PCF(PCF),
    .PredTakenF(predTaken1), .PredTargetF(predTarget1), .PredIdxF(predIdx1),
    .UpdateValidD(UpdateValidD), .UpdatePCD(UpdatePCD), .UpdateIdxD(UpdateIdxD),
    .UpdateTakenD(UpdateTakenD), .UpdateTargetD(UpdateTargetD),
    .UpdatePredTakenD(UpdatePredTakenD), .UpdatePredTargetD(UpdatePredTargetD),
    .MispredictD(mispred1), .CorrectPCD(correctPC1), .Ready(ready1),
    .BranchCount(branchCnt1), .MispredCount(mispredCnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] idx, input logic taken,
                     input logic [31:0] tgt, input logic predT, input logic [31:0] predTgt);
    UpdateValidD      = 1'b1;
    UpdatePCD         = pc;
    UpdateIdxD        = idx;
    UpdateTakenD      = taken;
    UpdateTargetD     = tgt;
    UpdatePredTakenD  = predT;
    UpdatePredTargetD = predTgt;
  endtask

  task automatic idle();
    UpdateValidD      = 1'b0;
    UpdatePCD         = '0;
    UpdateIdxD        = '0;
    UpdateTakenD      = 1'b0;
    UpdateTargetD     = '0;
    UpdatePredTakenD  = 1'b0;
    UpdatePredTargetD = '0;
  endtask

  // Advance past one rising edge, then settle away from the edge.
  task automatic step();
    @(negedge clk);
    idle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    PCF  = 32'h40;
    idle();
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    #1;
    chk("rst_branch_cnt", branchCnt0, 32'd0);
    chk("rst_mispred_cnt", mispredCnt0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("init_ready", {31'd0, ready0}, 32'd0);
      chk("init_taken", {31'd0, predTaken0}, 32'd0);
      chk("init_target", predTarget0, 32'h44);
      @(negedge clk);
      #1;
    end
    chk("ready_after_sweep", {31'd0, ready0}, 32'd1);

    // Allocate 0x40 -> 0x20, mispredicted (predicted not-taken).
    upd(32'h40, 4'd0, 1'b1, 32'h20, 1'b0, 32'h44);
    #1;
    chk("alloc_mispredict", {31'd0, mispred0}, 32'd1);
    chk("alloc_correct_pc", correctPC0, 32'h20);
    chk("alloc_same_cycle_lookup", {31'd0, predTaken0}, 32'd0);
    step();
    chk("alloc_branch_cnt", branchCnt0, 32'd1);
    chk("alloc_mispred_cnt", mispredCnt0, 32'd1);
    chk("alloc_pred_taken", {31'd0, predTaken0}, 32'd1);
    chk("alloc_pred_target", predTarget0, 32'h20);
    chk("alloc_pred_idx", {28'd0, predIdx0}, 32'd0);

    // Not-taken #1: ctr 10 -> 01, predicted taken so mispredicted.
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b1, 32'h20);
    #1;
    chk("nt1_mispredict", {31'd0, mispred0}, 32'd1);
    chk("nt1_correct_pc", correctPC0, 32'h44);
    step();
    chk("nt1_pred_taken", {31'd0, predTaken0}, 32'd0);
    chk("nt1_pred_target", predTarget0, 32'h44);
    chk("nt1_mispred_cnt", mispredCnt0, 32'd2);

    // Not-taken #2: ctr 01 -> 00, correctly predicted.
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 32'h44);
    #1;
    chk("nt2_mispredict", {31'd0, mispred0}, 32'd0);
    chk("nt2_correct_pc", correctPC0, 32'h44);
    step();
    chk("nt2_branch_cnt", branchCnt0, 32'd3);
    chk("nt2_mispred_cnt", mispredCnt0, 32'd2);

    // Not-taken #3: ctr saturates at 00.
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 32'h44);
    step();
    chk("sat_zero_pred_taken", {31'd0, predTaken0}, 32'd0);
    chk("sat_zero_branch_cnt", branchCnt0, 32'd4);

    // Aliasing: 0x80 maps to idx 0 with a different tag.
    PCF = 32'h80;
    #1;
    chk("alias_miss_taken", {31'd0, predTaken0}, 32'd0);
    chk("alias_miss_target", predTarget0, 32'h84);
    chk("alias_idx", {28'd0, predIdx0}, 32'd0);
    upd(32'h80, 4'd0, 1'b1, 32'h100, 1'b0, 32'h84);
    #1;
    chk("alias_mispredict", {31'd0, mispred0}, 32'd1);
    chk("alias_correct_pc", correctPC0, 32'h100);
    step();
    chk("alias_pred_taken", {31'd0, predTaken0}, 32'd1);
    chk("alias_pred_target", predTarget0, 32'h100);
    PCF = 32'h40;
    #1;
    chk("alias_evicted", {31'd0, predTaken0}, 32'd0);
    chk("alias_evicted_target", predTarget0, 32'h44);
    PCF = 32'h80;

    // Taken hit with a new target: target mismatch mispredicts, ctr 10 -> 11.
    upd(32'h80, 4'd0, 1'b1, 32'h200, 1'b1, 32'h100);
    #1;
    chk("retarget_mispredict", {31'd0, mispred0}, 32'd1);
    chk("retarget_correct_pc", correctPC0, 32'h200);
    step();
    chk("retarget_target", predTarget0, 32'h200);
    chk("retarget_mispred_cnt", mispredCnt0, 32'd4);

    // Taken at 11 saturates; a wrap would drop to 00 and predict not-taken.
    upd(32'h80, 4'd0, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    chk("sat_top_mispredict", {31'd0, mispred0}, 32'd0);
    step();
    chk("sat_top_pred_taken", {31'd0, predTaken0}, 32'd1);
    chk("sat_top_branch_cnt", branchCnt0, 32'd7);

    // Miss and not-taken leaves the entry untouched.
    PCF = 32'hC4;
    upd(32'hC4, 4'd1, 1'b0, 32'h0, 1'b0, 32'hC8);
    #1;
    chk("miss_nt_correct_pc", correctPC0, 32'hC8);
    chk("miss_nt_idx", {28'd0, predIdx0}, 32'd1);
    step();
    chk("miss_nt_pred_taken", {31'd0, predTaken0}, 32'd0);
    chk("miss_nt_branch_cnt", branchCnt0, 32'd8);

    // Verify is gated by valid; PC+4 wraps.
    UpdatePCD        = 32'hFFFF_FFFC;
    UpdatePredTakenD = 1'b1;
    UpdateTakenD     = 1'b0;
    #1;
    chk("invalid_no_mispredict", {31'd0, mispred0}, 32'd0);
    chk("wrap_correct_pc", correctPC0, 32'h0);
    idle();

    // Statistics counters saturate.
    dut0.branchCnt  = 32'hFFFF_FFFF;
    dut0.mispredCnt = 32'hFFFF_FFFF;
    upd(32'hC4, 4'd1, 1'b1, 32'h300, 1'b0, 32'hC8);
    step();
    chk("sat_branch_cnt", branchCnt0, 32'hFFFF_FFFF);
    chk("sat_mispred_cnt", mispredCnt0, 32'hFFFF_FFFF);

    // Gshare instance: release reset and let it sweep.
    PCF  = 32'h40;
    rst1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("g_init_ready", {31'd0, ready1}, 32'd0);
      @(negedge clk);
      #1;
    end
    chk("g_ready", {31'd0, ready1}, 32'd1);
    chk("g_idx0", {28'd0, predIdx1}, 32'd0);
    upd(32'h40, 4'd0, 1'b1, 32'h20, 1'b0, 32'h44);
    step();
    chk("g_idx_ghr1", {28'd0, predIdx1}, 32'd1);
    chk("g_miss_ghr1", {31'd0, predTaken1}, 32'd0);
    upd(32'h40, 4'd1, 1'b1, 32'h20, 1'b0, 32'h44);
    step();
    chk("g_idx_ghr3", {28'd0, predIdx1}, 32'd3);
    upd(32'h40, 4'd3, 1'b1, 32'h20, 1'b0, 32'h44);
    step();
    chk("g_idx_ghr7", {28'd0, predIdx1}, 32'd7);
    chk("g_miss_ghr7", {31'd0, predTaken1}, 32'd0);
    chk("g_branch_cnt", branchCnt1, 32'd3);

    // Mid-run reset for one edge; an update during INIT is dropped.
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    upd(32'h40, 4'd0, 1'b1, 32'h20, 1'b0, 32'h44);
    #1;
    chk("g_init_mispredict", {31'd0, mispred1}, 32'd1);
    chk("g_rst_branch_cnt", branchCnt1, 32'd0);
    chk("g_rst_mispred_cnt", mispredCnt1, 32'd0);
    chk("g_rst_idx", {28'd0, predIdx1}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("g_reinit_ready", {31'd0, ready1}, 32'd0);
      chk("g_reinit_taken", {31'd0, predTaken1}, 32'd0);
      step();
    end
    chk("g_reready", {31'd0, ready1}, 32'd1);
    chk("g_init_upd_dropped", branchCnt1, 32'd0);
    chk("g_ghr_kept_zero", {28'd0, predIdx1}, 32'd0);
    chk("g_table_invalidated", {31'd0, predTaken1}, 32'd0);
    chk("g_target_after_reinit", predTarget1, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
